// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer for a single-port SRAM: drives the memory test port,
// compares read data against the expected background and latches the first failure.
module mbist_march_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [2:0]        fail_elem_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;
    logic [2:0]        dcnt_q, dcnt_d;
    logic              done_q, done_d;
    logic              down, term, kill;
    logic [DATA_W-1:0] rbg, rd_exp;
    logic [2:0]        elem;

    logic [RD_LAT-1:0]             vld_pipe_q;
    logic [RD_LAT-1:0][DATA_W-1:0] exp_pipe_q;
    logic [RD_LAT-1:0][ADDR_W-1:0] adr_pipe_q;
    logic [RD_LAT-1:0][2:0]        elm_pipe_q;
    logic                          mism;
    logic                          fail_q;
    logic [ADDR_W-1:0]             fail_addr_q;
    logic [2:0]                    fail_elem_q;

    assign kill   = abort_i && (state_q != S_IDLE);
    assign down   = (state_q == S_M3) || (state_q == S_M4);
    assign term   = down ? (addr_q == '0) : (addr_q == LAST);
    assign rbg    = ((state_q == S_M2) || (state_q == S_M4)) ? '1 : '0;
    assign elem   = 3'(state_q) - 3'd1;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            phase_q <= 1'b0;
            dcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            dcnt_q  <= dcnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        dcnt_d      = dcnt_q;
        done_d      = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;
        mem_wdata_o = '0;
        rd_exp      = '0;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_M0;
                addr_d  = '0;
                phase_d = 1'b0;
            end
            S_M0: begin
                mem_addr_o = addr_q;
                mem_we_o   = 1'b1;
                if (term) begin
                    state_d = S_M1;
                    addr_d  = '0;
                end else addr_d = addr_q + 1'b1;
            end
            S_M1, S_M2, S_M3, S_M4: begin
                // read the old background, then overwrite with its complement
                mem_addr_o  = addr_q;
                mem_re_o    = !phase_q;
                mem_we_o    = phase_q;
                mem_wdata_o = ~rbg;
                rd_exp      = rbg;
                phase_d     = !phase_q;
                if (phase_q) begin
                    if (term) begin
                        state_d = state_t'(state_q + 3'd1);
                        addr_d  = ((state_q == S_M2) || (state_q == S_M3)) ? LAST : '0;
                    end else addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
                end
            end
            S_M5: begin
                mem_addr_o = addr_q;
                mem_re_o   = 1'b1;
                if (term) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                    dcnt_d  = '0;
                end else addr_d = addr_q + 1'b1;
            end
            S_DRAIN: begin
                if (dcnt_q == 3'(RD_LAT - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else dcnt_d = dcnt_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
        if (kill) begin
            state_d = S_IDLE;
            addr_d  = '0;
            phase_d = 1'b0;
            dcnt_d  = '0;
            done_d  = 1'b0;
        end
    end

    // expected data travels with the read so it lines up with mem_rdata_i
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe_q <= '0;
            exp_pipe_q <= '0;
            adr_pipe_q <= '0;
            elm_pipe_q <= '0;
        end else if (kill) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= mem_re_o;
            exp_pipe_q[0] <= rd_exp;
            adr_pipe_q[0] <= mem_addr_o;
            elm_pipe_q[0] <= elem;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                exp_pipe_q[i] <= exp_pipe_q[i-1];
                adr_pipe_q[i] <= adr_pipe_q[i-1];
                elm_pipe_q[i] <= elm_pipe_q[i-1];
            end
        end
    end

    assign mism = vld_pipe_q[RD_LAT-1] && (mem_rdata_i != exp_pipe_q[RD_LAT-1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else if ((state_q == S_IDLE) && start_i) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else if (mism) begin
            fail_q <= 1'b1;
            if (!fail_q) begin
                fail_addr_q <= adr_pipe_q[RD_LAT-1];
                fail_elem_q <= elm_pipe_q[RD_LAT-1];
            end
        end
    end

    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural SRAM with injectable stuck-at bit, March C-
// operation list built from the element table, and a per-cycle compare process.
module tb_mbist_march_ctrl;

    localparam int N = 16;
    localparam int NOPS = 10 * N;
    localparam int BUSY = NOPS + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] mem_addr;
    logic       mem_we, mem_re;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       busy, done, fail;
    logic [3:0] fail_addr;
    logic [2:0] fail_elem;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_re_o(mem_re),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .done_o(done), .fail_o(fail),
        .fail_addr_o(fail_addr), .fail_elem_o(fail_elem)
    );

    typedef struct {
        bit       we;
        bit       re;
        int       addr;
        bit [7:0] d;
        int       elem;
    } op_t;

    op_t ops[NOPS];
    int  n_cmp = 0;
    int  n_bad = 0;

    // stuck-at fault configuration
    bit  flt_en = 0;
    int  flt_a = 0;
    int  flt_b = 0;
    bit  flt_v = 0;

    // model expectations for the current run
    int  ff_idx = -1;
    int  ff_addr = 0;
    int  ff_elem = 0;
    int  abort_at = -1;

    // monitor state: -1 idle, -2 first cycle after abort, 0..BUSY busy/done cycles
    int  cyc = -1;
    int  busy_cnt = 0;
    int  n_runs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] faulty(input int a, input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (flt_en && a == flt_a) r[flt_b] = flt_v;
        return r;
    endfunction

    logic [7:0] sram[N];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= faulty(int'(mem_addr), sram[mem_addr]);
        if (mem_we) sram[mem_addr] <= mem_wdata;
    end

    task automatic put(inout int k, input bit we, input bit re, input int a,
                       input bit [7:0] d, input int e);
        ops[k].we = we; ops[k].re = re; ops[k].addr = a; ops[k].d = d; ops[k].elem = e;
        k++;
    endtask

    task automatic build_ops();
        int k;
        bit dn;
        bit [7:0] rb;
        k = 0;
        for (int a = 0; a < N; a++) put(k, 1, 0, a, 8'h00, 0);
        for (int e = 1; e <= 4; e++) begin
            dn = (e >= 3);
            rb = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            for (int i = 0; i < N; i++) begin
                put(k, 0, 1, dn ? N - 1 - i : i, rb, e);
                put(k, 1, 0, dn ? N - 1 - i : i, ~rb, e);
            end
        end
        for (int a = 0; a < N; a++) put(k, 0, 1, a, 8'h00, 5);
    endtask

    // walk the operation list against an ideal memory carrying the fault
    task automatic set_exp();
        logic [7:0] m[N];
        logic [7:0] v;
        for (int a = 0; a < N; a++) m[a] = 8'h00;
        ff_idx = -1; ff_addr = 0; ff_elem = 0;
        for (int i = 0; i < NOPS; i++) begin
            if (ops[i].we) m[ops[i].addr] = ops[i].d;
            if (ops[i].re) begin
                v = faulty(ops[i].addr, m[ops[i].addr]);
                if (v != ops[i].d && ff_idx < 0) begin
                    ff_idx = i; ff_addr = ops[i].addr; ff_elem = ops[i].elem;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cyc = -1;
            busy_cnt = 0;
        end else if (cyc < 0) begin
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_we", mem_we, 0);
            chk("idle_re", mem_re, 0);
            if (cyc == -2) begin
                chk("abort_fail", fail, (ff_idx >= 0 && ff_idx + 1 <= abort_at));
                chk("abort_faddr", fail_addr, (ff_idx >= 0 && ff_idx + 1 <= abort_at) ? ff_addr : 0);
                chk("abort_felem", fail_elem, (ff_idx >= 0 && ff_idx + 1 <= abort_at) ? ff_elem : 0);
            end
            cyc = start ? 0 : -1;
            busy_cnt = 0;
        end else if (cyc < BUSY) begin
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            if (cyc < NOPS) begin
                chk("op_we", mem_we, ops[cyc].we);
                chk("op_re", mem_re, ops[cyc].re);
                chk("op_addr", mem_addr, ops[cyc].addr);
                if (ops[cyc].we) chk("op_wdata", mem_wdata, ops[cyc].d);
            end else begin
                chk("drain_we", mem_we, 0);
                chk("drain_re", mem_re, 0);
            end
            busy_cnt++;
            cyc = abort ? -2 : cyc + 1;
        end else begin
            chk("end_busy", busy, 0);
            chk("end_done", done, 1);
            chk("busy_cycles", busy_cnt, BUSY);
            chk("end_fail", fail, ff_idx >= 0);
            chk("end_faddr", fail_addr, ff_addr);
            chk("end_felem", fail_elem, ff_elem);
            n_runs++;
            cyc = start ? 0 : -1;
            busy_cnt = 0;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_runs(input int target);
        int t;
        t = 0;
        while (n_runs < target && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("runs_reached", n_runs, target);
    endtask

    task automatic wait_cyc(input int c);
        int t;
        t = 0;
        while (cyc != c && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("cycle_reached", cyc, c);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_fail"}, fail, 0);
        chk({tag, "_faddr"}, fail_addr, 0);
        chk({tag, "_felem"}, fail_elem, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_re"}, mem_re, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        int nw0, nr5;
        build_ops();
        for (int a = 0; a < N; a++) sram[a] = 8'h00;

        // hand-computed anchors for the operation list
        nw0 = 0; nr5 = 0;
        for (int i = 0; i < NOPS; i++) begin
            if (ops[i].elem == 0 && ops[i].we && ops[i].d == 8'h00) nw0++;
            if (ops[i].elem == 5 && ops[i].re) nr5++;
        end
        chk("pin_m0_writes", nw0, 16);
        chk("pin_m5_reads", nr5, 16);
        chk("pin_m3_first_re", ops[80].re, 1);
        chk("pin_m3_first_addr", ops[80].addr, 15);
        chk("pin_m3_second_addr", ops[81].addr, 15);
        chk("pin_m3_wdata", ops[81].d, 8'hFF);
        chk("pin_m3_third_addr", ops[82].addr, 14);
        chk("pin_m4_last_addr", ops[143].addr, 0);
        chk("pin_m4_last_we", ops[143].we, 1);
        chk("pin_m5_first_addr", ops[144].addr, 0);
        chk("pin_m5_first_elem", ops[144].elem, 5);

        #12;
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // fault-free run
        flt_en = 0;
        set_exp();
        chk("pin_clean_nofail", ff_idx, -1);
        pulse_start();
        wait_runs(1);

        // addr 5 bit 0 stuck-at-1: first seen in M1
        flt_en = 1; flt_a = 5; flt_b = 0; flt_v = 1;
        set_exp();
        chk("pin_sa1_addr", ff_addr, 5);
        chk("pin_sa1_elem", ff_elem, 1);
        pulse_start();
        wait_runs(2);

        // addr 9 bit 7 stuck-at-0: first seen in M2, M4 must not overwrite
        flt_en = 1; flt_a = 9; flt_b = 7; flt_v = 0;
        set_exp();
        chk("pin_sa0_addr", ff_addr, 9);
        chk("pin_sa0_elem", ff_elem, 2);
        pulse_start();
        wait_runs(3);

        // abort during busy cycle 50 with a failure already latched
        flt_en = 1; flt_a = 5; flt_b = 0; flt_v = 1;
        set_exp();
        abort_at = 49;
        pulse_start();
        wait_cyc(49);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_run", n_runs, 3);
        flt_en = 0;
        set_exp();
        pulse_start();
        wait_runs(4);

        // start held high: ignored mid-run, re-accepted right after done
        start = 1'b1;
        wait_runs(5);
        wait_cyc(80);
        #2;
        rst = 1'b0;
        start = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // start and abort together in IDLE: start wins
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        wait_runs(6);
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
